uart_rx_core: RTL and testbench

- UART receiver feeding the SoC's serial console/loader input (the uart_rx pin taken from ui_in[0] at the chip top).
- Synchronises the asynchronous RX pin and oversamples 16x with majority voting.
- Frames 8N1 characters and presents each byte on a single-entry valid/ready output to the SoC's UART peripheral.
- Reports framing and overrun events as single-cycle pulses.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_rx_core.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared constants, state encodings and helpers for the 16x oversampling UART receiver.
package uart_pkg;

    // Oversampling geometry: 16 samples per bit, vote on samples 7/8/9.
    localparam int          OVS       = 16;
    localparam int          S_W       = $clog2(OVS);
    localparam logic [3:0]  VOTE_S0   = 4'd7;
    localparam logic [3:0]  VOTE_S1   = 4'd8;
    localparam logic [3:0]  VOTE_S2   = 4'd9;
    localparam logic [3:0]  LAST_S    = 4'd15;
    localparam int          DATA_BITS = 8;
    localparam logic [2:0]  LAST_IDX  = 3'd7;

    // Receiver FSM encoding.
    localparam logic [2:0]  ST_IDLE   = 3'd0;
    localparam logic [2:0]  ST_START  = 3'd1;
    localparam logic [2:0]  ST_DATA   = 3'd2;
    localparam logic [2:0]  ST_STOP   = 3'd3;
    localparam logic [2:0]  ST_BREAK  = 3'd4;

    typedef logic [2:0] uart_state_t;

    // 2-of-3 majority used to decide each bit value.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Oversample tick generator: counts 0..TICK_DIV-1 while enabled, held at 0 while cleared.
module uart_baud_tick #(
    parameter int TICK_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear, wrap at the last phase, or advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick_o = (!clr_i) && (cnt_q == LAST);

    // Divider counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// 8N1 UART receiver: input synchroniser, 16x oversampling with 2-of-3 vote,
// framing FSM and a single-entry valid/ready holding register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int TICK_DIV    = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    uart_state_t            state_q, state_d;
    logic [S_W-1:0]         s_q, s_d;
    logic [2:0]             idx_q, idx_d;
    logic                   v7_q, v7_d, v8_q, v8_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, busy_d;

    logic rx_s, tick_s, vote_s, vote_now_s, bit_done_s, deliver_s;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};

    // The divider is parked at phase 0 while idle so ticks align to the start edge.
    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick_s)
    );

    assign vote_s     = maj3(v7_q, v8_q, rx_s);
    assign vote_now_s = tick_s && (s_q == VOTE_S2);
    assign bit_done_s = tick_s && (s_q == LAST_S);

    // Framing FSM, sample capture and holding-register update.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        idx_d     = idx_q;
        v7_d      = v7_q;
        v8_d      = v8_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        deliver_s = 1'b0;

        if (tick_s) begin
            s_d = s_q + S_W'(1);
        end else begin
            s_d = s_q;
        end

        if (tick_s && (s_q == VOTE_S0)) begin
            v7_d = rx_s;
        end else begin
            v7_d = v7_q;
        end

        if (tick_s && (s_q == VOTE_S1)) begin
            v8_d = rx_s;
        end else begin
            v8_d = v8_q;
        end

        case (state_q)
            ST_IDLE: begin
                s_d   = '0;
                idx_d = 3'd0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (vote_now_s && vote_s) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                end else if (bit_done_s) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (vote_now_s) begin
                    shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (bit_done_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (vote_now_s) begin
                    s_d = '0;
                    if (vote_s) begin
                        deliver_s = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
            end
        endcase

        // Single-entry holding register: accept, replace-on-accept, or drop with overrun.
        if (deliver_s) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '1;
            state_q <= ST_IDLE;
            s_q     <= '0;
            idx_q   <= 3'd0;
            v7_q    <= 1'b1;
            v8_q    <= 1'b1;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            v7_q    <= v7_d;
            v8_q    <= v8_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_core with TICK_DIV=4 (64 clk per bit).
module tb_uart_rx_core;

    localparam int BIT_CYC = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;

    // Event counters fed by the monitor below.
    int         acc_cnt  = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    logic [7:0] acc_data = 8'h00;

    uart_rx_core #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Record handshakes and pulses on the falling edge.
    always @(negedge clk) begin
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            acc_cnt  <= acc_cnt + 1;
            acc_data <= data_o;
        end
        if (frame_err_o === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (overrun_o === 1'b1)   ovr_cnt  <= ovr_cnt + 1;
    end

    task automatic drive_bit(input logic v, input int n);
        rx_i = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends start + 8 data (LSB first) + stop; optionally inverts one cycle
    // of frame bit spike_bit at the s=8 sample position.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int spike_bit);
        logic v;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = stop_v;
            else             v = d[b-1];
            for (int j = 0; j < BIT_CYC; j++) begin
                rx_i = (b == spike_bit && j == 36) ? ~v : v;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_i = 1'b1; ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (data_o !== 8'h00)      begin failures++; $display("FAIL reset_data got=%h exp=00", data_o); end
        checks++; if (valid_o !== 1'b0)      begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (frame_err_o !== 1'b0)  begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0)    begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun_o); end
        checks++; if (busy_o !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rst_n = 1'b1;
        drive_bit(1'b1, 10);
    endtask

    task automatic test_single_byte();
        int a0, f0, o0;
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        ready_i = 1'b1;
        send_frame(8'hA5, 1'b1, -1);
        drive_bit(1'b1, 4);
        checks++; if (acc_cnt - a0 !== 1)    begin failures++; $display("FAIL a5_count got=%0d exp=1", acc_cnt - a0); end
        checks++; if (acc_data !== 8'hA5)    begin failures++; $display("FAIL a5_data got=%h exp=a5", acc_data); end
        checks++; if (ferr_cnt - f0 !== 0)   begin failures++; $display("FAIL a5_ferr got=%0d exp=0", ferr_cnt - f0); end
        checks++; if (ovr_cnt - o0 !== 0)    begin failures++; $display("FAIL a5_ovr got=%0d exp=0", ovr_cnt - o0); end
        checks++; if (busy_o !== 1'b0)       begin failures++; $display("FAIL a5_busy got=%b exp=0", busy_o); end
        checks++; if (valid_o !== 1'b0)      begin failures++; $display("FAIL a5_valid got=%b exp=0", valid_o); end
    endtask

    task automatic test_back_to_back();
        int a0, o0;
        a0 = acc_cnt; o0 = ovr_cnt;
        ready_i = 1'b0;
        send_frame(8'h3C, 1'b1, -1);
        send_frame(8'hC3, 1'b1, -1);
        drive_bit(1'b1, 10);
        checks++; if (valid_o !== 1'b1)      begin failures++; $display("FAIL b2b_valid got=%b exp=1", valid_o); end
        checks++; if (data_o !== 8'h3C)      begin failures++; $display("FAIL b2b_data got=%h exp=3c", data_o); end
        checks++; if (ovr_cnt - o0 !== 1)    begin failures++; $display("FAIL b2b_ovr got=%0d exp=1", ovr_cnt - o0); end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        drive_bit(1'b1, 10);
        checks++; if (acc_cnt - a0 !== 1)    begin failures++; $display("FAIL b2b_count got=%0d exp=1", acc_cnt - a0); end
        checks++; if (acc_data !== 8'h3C)    begin failures++; $display("FAIL b2b_acc got=%h exp=3c", acc_data); end
        checks++; if (valid_o !== 1'b0)      begin failures++; $display("FAIL b2b_drain got=%b exp=0", valid_o); end
    endtask

    task automatic test_glitch();
        int a0, f0;
        a0 = acc_cnt; f0 = ferr_cnt;
        ready_i = 1'b1;
        drive_bit(1'b0, 10);
        checks++; if (busy_o !== 1'b1)       begin failures++; $display("FAIL glitch_busy_mid got=%b exp=1", busy_o); end
        drive_bit(1'b0, 10);
        drive_bit(1'b1, 100);
        checks++; if (busy_o !== 1'b0)       begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy_o); end
        checks++; if (valid_o !== 1'b0)      begin failures++; $display("FAIL glitch_valid got=%b exp=0", valid_o); end
        checks++; if (acc_cnt - a0 !== 0)    begin failures++; $display("FAIL glitch_count got=%0d exp=0", acc_cnt - a0); end
        checks++; if (ferr_cnt - f0 !== 0)   begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
    endtask

    task automatic test_frame_error_break();
        int a0, f0;
        a0 = acc_cnt; f0 = ferr_cnt;
        ready_i = 1'b1;
        send_frame(8'h55, 1'b0, -1);
        drive_bit(1'b0, 500);
        checks++; if (ferr_cnt - f0 !== 1)   begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
        checks++; if (acc_cnt - a0 !== 0)    begin failures++; $display("FAIL ferr_nodata got=%0d exp=0", acc_cnt - a0); end
        checks++; if (busy_o !== 1'b1)       begin failures++; $display("FAIL break_busy got=%b exp=1", busy_o); end
        drive_bit(1'b1, 20);
        checks++; if (busy_o !== 1'b0)       begin failures++; $display("FAIL break_exit got=%b exp=0", busy_o); end
        send_frame(8'h81, 1'b1, -1);
        drive_bit(1'b1, 4);
        checks++; if (acc_cnt - a0 !== 1)    begin failures++; $display("FAIL after_break_count got=%0d exp=1", acc_cnt - a0); end
        checks++; if (acc_data !== 8'h81)    begin failures++; $display("FAIL after_break_data got=%h exp=81", acc_data); end
        checks++; if (ferr_cnt - f0 !== 1)   begin failures++; $display("FAIL after_break_ferr got=%0d exp=1", ferr_cnt - f0); end
    endtask

    task automatic test_majority();
        int a0;
        a0 = acc_cnt;
        ready_i = 1'b1;
        send_frame(8'hFF, 1'b1, 4);
        drive_bit(1'b1, 4);
        checks++; if (acc_cnt - a0 !== 1)    begin failures++; $display("FAIL vote_count got=%0d exp=1", acc_cnt - a0); end
        checks++; if (acc_data !== 8'hFF)    begin failures++; $display("FAIL vote_data got=%h exp=ff", acc_data); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int a0, f0, o0;
        ready_i = 1'b0;
        send_frame(8'h5A, 1'b1, -1);
        drive_bit(1'b1, 4);
        checks++; if (valid_o !== 1'b1)      begin failures++; $display("FAIL pre_rst_valid got=%b exp=1", valid_o); end
        d = 8'hE7;
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CYC);
        drive_bit(d[4], 20);
        checks++; if (busy_o !== 1'b1)       begin failures++; $display("FAIL pre_rst_busy got=%b exp=1", busy_o); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (data_o !== 8'h00)      begin failures++; $display("FAIL mid_rst_data got=%h exp=00", data_o); end
        checks++; if (valid_o !== 1'b0)      begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", valid_o); end
        checks++; if (busy_o !== 1'b0)       begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy_o); end
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        drive_bit(1'b1, 200);
        ready_i = 1'b1;
        send_frame(8'h12, 1'b1, -1);
        drive_bit(1'b1, 4);
        checks++; if (acc_cnt - a0 !== 1)    begin failures++; $display("FAIL post_rst_count got=%0d exp=1", acc_cnt - a0); end
        checks++; if (acc_data !== 8'h12)    begin failures++; $display("FAIL post_rst_data got=%h exp=12", acc_data); end
        checks++; if (ferr_cnt - f0 + ovr_cnt - o0 !== 0) begin failures++; $display("FAIL post_rst_pulses got=%0d exp=0", ferr_cnt - f0 + ovr_cnt - o0); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error_break();
        test_majority();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
